// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package  : mips_defs
//  Purpose  : Shared state encodings, opcode/funct constants and ALU codes
//             for the multicycle MIPS-subset controller.
//  Revision : 1.0  initial release
// ============================================================================
package mips_defs;

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_HALT    = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] c_OP_LB   = 6'b100000;
    localparam logic [5:0] c_OP_SB   = 6'b101000;
    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Maps the FSM's ALU operation class plus funct to alucontrol.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decoder
    import mips_defs::*;
#(
    parameter int FNW = 6
) (
    input  aluop_t         i_aluop,
    input  logic [FNW-1:0] i_funct,
    output logic [2:0]     o_alucontrol
);

    always_comb begin
        o_alucontrol = c_ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = c_ALU_ADD;
            ALUOP_SUB: o_alucontrol = c_ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct falls back to add; the R-type writeback still happens.
                case (i_funct)
                    FNW'(c_FN_ADD): o_alucontrol = c_ALU_ADD;
                    FNW'(c_FN_SUB): o_alucontrol = c_ALU_SUB;
                    FNW'(c_FN_AND): o_alucontrol = c_ALU_AND;
                    FNW'(c_FN_OR):  o_alucontrol = c_ALU_OR;
                    FNW'(c_FN_SLT): o_alucontrol = c_ALU_SLT;
                    default:        o_alucontrol = c_ALU_ADD;
                endcase
            end
            default: o_alucontrol = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mips_controller
//  Purpose  : Multicycle Moore control FSM for the 8-bit MIPS-subset datapath.
//  Revision : 1.0  initial release
// ============================================================================
module mips_controller
    import mips_defs::*;
#(
    parameter int OPW              = 6,
    parameter int FNW              = 6,
    parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    output logic           memread,
    output logic           memwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [2:0]     alucontrol,
    output logic           iord,
    output logic [3:0]     irwrite,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic [1:0]     pcsource,
    output logic           pcen,
    output logic           halt
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH1;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_aluop   = ALUOP_ADD;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        iord      = 1'b0;
        irwrite   = 4'b0000;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        regwrite  = 1'b0;
        pcsource  = 2'b00;
        halt      = 1'b0;
        case (r_state)
            S_FETCH1: begin
                memread = 1'b1; alusrcb = 2'b01; irwrite = 4'b0001; w_pcwrite = 1'b1;
                w_next  = S_FETCH2;
            end
            S_FETCH2: begin
                memread = 1'b1; alusrcb = 2'b01; irwrite = 4'b0010; w_pcwrite = 1'b1;
                w_next  = S_FETCH3;
            end
            S_FETCH3: begin
                memread = 1'b1; alusrcb = 2'b01; irwrite = 4'b0100; w_pcwrite = 1'b1;
                w_next  = S_FETCH4;
            end
            S_FETCH4: begin
                memread = 1'b1; alusrcb = 2'b01; irwrite = 4'b1000; w_pcwrite = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into aluout while the opcode is decoded.
                alusrcb = 2'b11;
                case (op)
                    OPW'(c_OP_LB):   w_next = S_MEMADR;
                    OPW'(c_OP_SB):   w_next = S_MEMADR;
                    OPW'(c_OP_R):    w_next = S_RTYPEEX;
                    OPW'(c_OP_BEQ):  w_next = S_BEQEX;
                    OPW'(c_OP_J):    w_next = S_JEX;
                    OPW'(c_OP_ADDI): w_next = S_ADDIEX;
                    default:         w_next = ILLEGAL_TO_FETCH ? S_FETCH1 : S_HALT;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1; alusrcb = 2'b10;
                w_next  = (op == OPW'(c_OP_LB)) ? S_LBRD : S_SBWR;
            end
            S_LBRD: begin
                memread = 1'b1; iord = 1'b1;
                w_next  = S_LBWR;
            end
            S_LBWR: begin
                regwrite = 1'b1; memtoreg = 1'b1;
                w_next   = S_FETCH1;
            end
            S_SBWR: begin
                memwrite = 1'b1; iord = 1'b1;
                w_next   = S_FETCH1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1; w_aluop = ALUOP_FUNCT;
                w_next  = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1; regdst = 1'b1;
                w_next   = S_FETCH1;
            end
            S_BEQEX: begin
                alusrca = 1'b1; w_aluop = ALUOP_SUB; pcsource = 2'b01; w_branch = 1'b1;
                w_next  = S_FETCH1;
            end
            S_JEX: begin
                pcsource = 2'b10; w_pcwrite = 1'b1;
                w_next   = S_FETCH1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1; alusrcb = 2'b10;
                w_next  = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite = 1'b1;
                w_next   = S_FETCH1;
            end
            S_HALT: begin
                halt   = 1'b1;
                w_next = S_HALT;
            end
            default: w_next = S_FETCH1;
        endcase
    end

    assign pcen = w_pcwrite | (w_branch & zero);

    alu_decoder #(
        .FNW (FNW)
    ) u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_controller
//  Purpose  : Self-checking bench; two controllers (illegal->fetch, illegal->halt)
//             compared every cycle against an instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       iord;
        logic [3:0] irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [1:0] pcsource;
        logic       pcen;
        logic       halt;
    } outs_t;

    // Symbolic instruction steps used by the model.
    localparam int K_F1 = 0, K_F2 = 1, K_F3 = 2, K_F4 = 3, K_DEC = 4, K_MADR = 5,
                   K_LBRD = 6, K_LBWR = 7, K_SBWR = 8, K_REX = 9, K_RWR = 10,
                   K_BEQ = 11, K_JEX = 12, K_AEX = 13, K_AWR = 14, K_HALT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    wire outs_t o_a;
    wire outs_t o_b;

    int n_cmp = 0;
    int n_err = 0;
    bit h_halted = 1'b0;

    always #5 clk = ~clk;

    mips_controller #(.OPW(6), .FNW(6), .ILLEGAL_TO_FETCH(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(o_a.memread), .memwrite(o_a.memwrite), .alusrca(o_a.alusrca),
        .alusrcb(o_a.alusrcb), .alucontrol(o_a.alucontrol), .iord(o_a.iord),
        .irwrite(o_a.irwrite), .memtoreg(o_a.memtoreg), .regdst(o_a.regdst),
        .regwrite(o_a.regwrite), .pcsource(o_a.pcsource), .pcen(o_a.pcen), .halt(o_a.halt)
    );

    mips_controller #(.OPW(6), .FNW(6), .ILLEGAL_TO_FETCH(1'b0)) dut_h (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(o_b.memread), .memwrite(o_b.memwrite), .alusrca(o_b.alusrca),
        .alusrcb(o_b.alusrcb), .alucontrol(o_b.alucontrol), .iord(o_b.iord),
        .irwrite(o_b.irwrite), .memtoreg(o_b.memtoreg), .regdst(o_b.regdst),
        .regwrite(o_b.regwrite), .pcsource(o_b.pcsource), .pcen(o_b.pcen), .halt(o_b.halt)
    );

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic outs_t expect_k(input int k, input logic [5:0] f, input logic z);
        outs_t e;
        e = '0;
        e.alucontrol = 3'b010;
        case (k)
            K_F1, K_F2, K_F3, K_F4: begin
                e.memread = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1;
                e.irwrite = 4'(1 << k);
            end
            K_DEC:  e.alusrcb = 2'b11;
            K_MADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            K_LBRD: begin e.memread = 1'b1; e.iord = 1'b1; end
            K_LBWR: begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            K_SBWR: begin e.memwrite = 1'b1; e.iord = 1'b1; end
            K_REX:  begin e.alusrca = 1'b1; e.alucontrol = funct_alu(f); end
            K_RWR:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            K_BEQ:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsource = 2'b01; e.pcen = z; end
            K_JEX:  begin e.pcsource = 2'b10; e.pcen = 1'b1; end
            K_AEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            K_AWR:  e.regwrite = 1'b1;
            K_HALT: e.halt = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input outs_t obs, input outs_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic inv(input string tag, input outs_t o);
        logic ok;
        ok = !(o.memread & o.memwrite) && !(o.regwrite & o.memwrite) && $onehot0(o.irwrite);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s_excl observed=%h expected=exclusive strobes", tag, o);
        end
    endtask

    // One clock cycle: drive zero, settle, check both DUTs, advance to next negedge.
    task automatic cycle(input int k, input int zf);
        int kh;
        zero = (zf == 2) ? 1'($urandom_range(0, 1)) : 1'(zf);
        #1;
        kh = h_halted ? K_HALT : k;
        chk($sformatf("dut_k%0d_op%b", k, op), o_a, expect_k(k, funct, zero));
        chk($sformatf("dut_h_k%0d_op%b", kh, op), o_b, expect_k(kh, funct, zero));
        inv("dut", o_a);
        inv("dut_h", o_b);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf);
        int q[$];
        op = o;
        funct = f;
        q = '{K_F1, K_F2, K_F3, K_F4, K_DEC};
        case (o)
            6'b100000: q = {q, K_MADR, K_LBRD, K_LBWR};
            6'b101000: q = {q, K_MADR, K_SBWR};
            6'b000000: q = {q, K_REX, K_RWR};
            6'b000100: q.push_back(K_BEQ);
            6'b000010: q.push_back(K_JEX);
            6'b001000: q = {q, K_AEX, K_AWR};
            default: ;
        endcase
        foreach (q[i]) begin
            cycle(q[i], zf);
            if (q[i] == K_DEC && !is_legal(o)) h_halted = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        @(negedge clk);
        h_halted = 1'b0;
        repeat (n - 1) cycle(K_F1, 2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;

        do_reset(2);
        run_instr(6'b000000, 6'b100010, 2);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b100000, 6'b000000, 2);
        run_instr(6'b101000, 6'b000000, 2);

        // Reset held for two edges while the fetch is in its third byte.
        op = 6'b001000;
        cycle(K_F1, 2);
        cycle(K_F2, 2);
        reset = 1'b1;
        cycle(K_F3, 2);
        h_halted = 1'b0;
        cycle(K_F1, 2);
        reset = 1'b0;
        run_instr(6'b001000, 6'b000000, 2);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(ops[$urandom_range(0, 5)], f, 2);
        end

        // Illegal opcode: one instance refetches, the other halts until reset.
        run_instr(6'b111111, 6'b000000, 2);
        run_instr(6'b001000, 6'b000000, 2);
        run_instr(6'b000000, 6'b100101, 2);
        do_reset(2);
        run_instr(6'b000010, 6'b000000, 2);
        run_instr(6'b000000, 6'b101010, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
